// File: rtl/beat_generator.sv
// Beat generator: turns the tempo terminal count into a one-cycle beat
// pulse, tracks the step within a measure and flags measure wrap.
module beat_generator #(
    parameter int TEMPO_W = 22,
    parameter int STEPS   = 8,
    parameter int STEP_W  = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               run,
    input  logic               restart,
    output logic               beat_pulse,
    output logic [STEP_W-1:0]  step,
    output logic               measure_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    state_t             state_q;
    logic [TEMPO_W-1:0] cnt_q;
    logic [TEMPO_W-1:0] tempo_q;
    logic [STEP_W-1:0]  step_q;
    logic               beat_q;
    logic               meas_q;

    wire term = (cnt_q == tempo_q);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tempo_q <= '0;
            step_q  <= '0;
            beat_q  <= 1'b0;
            meas_q  <= 1'b0;
        end else if (restart) begin
            cnt_q   <= '0;
            tempo_q <= tempo;
            step_q  <= '0;
            beat_q  <= 1'b0;
            meas_q  <= 1'b0;
        end else begin
            beat_q <= 1'b0;
            meas_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (run) begin
                        state_q <= RUN;
                        tempo_q <= tempo;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Pause: step is kept so play resumes mid-measure
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (term) begin
                        cnt_q   <= '0;
                        tempo_q <= tempo;
                        beat_q  <= 1'b1;
                        meas_q  <= (step_q == LAST);
                        step_q  <= (step_q == LAST) ? '0 : step_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign beat_pulse    = beat_q;
    assign measure_pulse = meas_q;
    assign step          = step_q;

endmodule

// File: tb/tb_beat_generator.sv
// Directed self-checking bench for beat_generator.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_beat_generator;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [21:0] tempo = '0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic        beat_pulse;
    logic [2:0]  step;
    logic        measure_pulse;

    int checks = 0;
    int errors = 0;

    beat_generator dut (
        .clk(clk),
        .n_rst(n_rst),
        .tempo(tempo),
        .run(run),
        .restart(restart),
        .beat_pulse(beat_pulse),
        .step(step),
        .measure_pulse(measure_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        run = 1'b0;
        restart = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        run = 1'b1;
        tempo = 22'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({beat_pulse, measure_pulse, step} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold: beat=%0b meas=%0b step=%0d want 0/0/0",
                         beat_pulse, measure_pulse, step);
            end
        end
        n_rst = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (beat_pulse !== (i == 6)) begin
                errors++;
                $display("FAIL reset_first_beat: cyc %0d beat=%0b want %0b",
                         i, beat_pulse, (i == 6));
            end
        end
        checks++;
        if (step !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_step: step=%0d want 1", step);
        end
    endtask

    task automatic test_steady();
        int beats = 0;
        logic [2:0] es = 3'd0;
        do_reset();
        tempo = 22'd3;
        run = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i % 4 == 0) begin
                es = es + 3'd1;
                beats++;
            end
            checks++;
            if (beat_pulse !== (i % 4 == 0) || step !== es ||
                measure_pulse !== (i % 4 == 0 && es == 3'd0)) begin
                errors++;
                $display("FAIL steady: cyc %0d beat=%0b step=%0d meas=%0b want %0b/%0d/%0b",
                         i, beat_pulse, step, measure_pulse, (i % 4 == 0), es,
                         (i % 4 == 0 && es == 3'd0));
            end
        end
        checks++;
        if (beats != 10 || step !== 3'd2) begin
            errors++;
            $display("FAIL steady_count: step=%0d want 2 after 10 beats", step);
        end
    endtask

    task automatic test_tempo_change();
        do_reset();
        tempo = 22'd9;
        run = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 4) tempo = 22'd2;
            checks++;
            if (beat_pulse !== (i == 10 || i == 13 || i == 16)) begin
                errors++;
                $display("FAIL tempo_change: cyc %0d beat=%0b want %0b",
                         i, beat_pulse, (i == 10 || i == 13 || i == 16));
            end
        end
        checks++;
        if (step !== 3'd3) begin
            errors++;
            $display("FAIL tempo_change_step: step=%0d want 3", step);
        end
    endtask

    task automatic test_pause();
        do_reset();
        tempo = 22'd4;
        run = 1'b1;
        tick();
        repeat (17) tick();
        checks++;
        if (step !== 3'd3) begin
            errors++;
            $display("FAIL pause_setup: step=%0d want 3", step);
        end
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (beat_pulse !== 1'b0 || step !== 3'd3) begin
                errors++;
                $display("FAIL pause_hold: cyc %0d beat=%0b step=%0d want 0/3",
                         i, beat_pulse, step);
            end
        end
        run = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (beat_pulse !== (i == 5) || step !== ((i == 5) ? 3'd4 : 3'd3)) begin
                errors++;
                $display("FAIL resume: cyc %0d beat=%0b step=%0d want %0b/%0d",
                         i, beat_pulse, step, (i == 5), (i == 5) ? 4 : 3);
            end
        end
    endtask

    task automatic test_restart_terminal();
        do_reset();
        tempo = 22'd2;
        run = 1'b1;
        tick();
        repeat (20) tick();
        checks++;
        if (step !== 3'd6) begin
            errors++;
            $display("FAIL restart_setup: step=%0d want 6", step);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checks++;
        if (beat_pulse !== 1'b0 || step !== 3'd0 || measure_pulse !== 1'b0) begin
            errors++;
            $display("FAIL restart_suppress: beat=%0b step=%0d meas=%0b want 0/0/0",
                     beat_pulse, step, measure_pulse);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (beat_pulse !== (i == 3) || step !== ((i == 3) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL restart_next: cyc %0d beat=%0b step=%0d want %0b/%0d",
                         i, beat_pulse, step, (i == 3), (i == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_tempo_zero();
        do_reset();
        tempo = 22'd0;
        run = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (beat_pulse !== 1'b1 || step !== 3'(i % 8) ||
                measure_pulse !== (i % 8 == 0)) begin
                errors++;
                $display("FAIL tempo_zero: cyc %0d beat=%0b step=%0d meas=%0b want 1/%0d/%0b",
                         i, beat_pulse, step, measure_pulse, i % 8, (i % 8 == 0));
            end
        end
        n_rst = 1'b0;
        tick();
        checks++;
        if ({beat_pulse, measure_pulse, step} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: beat=%0b meas=%0b step=%0d want 0/0/0",
                     beat_pulse, measure_pulse, step);
        end
        n_rst = 1'b1;
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_tempo_change();
        test_pause();
        test_restart_terminal();
        test_tempo_zero();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
